// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// rs232_pkg
//   Shared definitions for the Daisho RS-232 target: vendor request codes,
//   baud divisor limits, OUT-path FSM encoding and small helpers.
//   Revision: 1.0
// ============================================================================
package rs232_pkg;

  // Vendor request codes shared with the capture path
  localparam logic [7:0]  VR_READ          = 8'h01;
  localparam logic [7:0]  VR_SET_BAUD      = 8'h02;

  // 125 MHz / 115200 baud
  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd1085;
  localparam logic [15:0] BAUD_DIV_MIN     = 16'd16;

  // Endpoint buffer holds 512 bytes; longer committed lengths are clamped
  localparam logic [9:0]  MAX_PKT_LEN      = 10'd512;

  // Bit index of the stop bit within a frame (0 = start, 1..8 = data)
  localparam logic [3:0]  UART_STOP_BIT    = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_SEND  = 3'd4,
    ST_ARM   = 3'd5,
    ST_DRAIN = 3'd6
  } out_state_e;

  function automatic logic [9:0] clamp_len(input logic [9:0] len);
    return (len > MAX_PKT_LEN) ? MAX_PKT_LEN : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// uart_tx_8n1
//   8N1 serializer. The divisor is latched at each start so a divisor change
//   never disturbs a frame in flight. ready also rises on the last clock of
//   the stop bit, allowing gap-free back-to-back frames.
//   Revision: 1.0
// ============================================================================
module uart_tx_8n1
  import rs232_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  data,
  input  logic [15:0] div,
  output logic        txd,
  output logic        ready
);

  logic        txd_q;
  logic        busy_q;
  logic [15:0] div_q;
  logic [15:0] baud_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;

  logic bit_end;
  logic stop_end;

  assign bit_end  = (baud_cnt_q == 16'd0);
  assign stop_end = busy_q && bit_end && (bit_cnt_q == UART_STOP_BIT);
  assign ready    = !busy_q || stop_end;
  assign txd      = txd_q;

  // Frame sequencer: a start (when ready) has priority and reloads everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      div_q      <= 16'd0;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
    end else if (start && ready) begin
      busy_q     <= 1'b1;
      txd_q      <= 1'b0;
      shift_q    <= data;
      bit_cnt_q  <= 4'd0;
      div_q      <= div;
      baud_cnt_q <= div - 16'd1;
    end else if (busy_q) begin
      if (!bit_end) begin
        baud_cnt_q <= baud_cnt_q - 16'd1;
      end else if (bit_cnt_q == UART_STOP_BIT) begin
        busy_q <= 1'b0;
      end else begin
        baud_cnt_q <= div_q - 16'd1;
        bit_cnt_q  <= bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd8) begin
          txd_q <= 1'b1;
        end else begin
          txd_q   <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_rs232_out.sv
`default_nettype none
// ============================================================================
// io_rs232_out
//   USB OUT endpoint to RS-232 TXD. Fetches committed packet bytes from the
//   endpoint buffer, serializes them as 8N1 with CTS flow control, prefetches
//   the next byte while the current frame is on the line, and re-arms the
//   endpoint once the packet is fully sent.
//   Revision: 1.0
// ============================================================================
module io_rs232_out
  import rs232_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  output logic [8:0]  buf_out_addr,
  input  logic [7:0]  buf_out_q,
  input  logic [9:0]  buf_out_len,
  input  logic        buf_out_hasdata,
  output logic        buf_out_arm,
  input  logic        buf_out_arm_ack,
  input  logic        vend_req_act,
  input  logic [7:0]  vend_req_request,
  input  logic [15:0] vend_req_val,
  output logic        rs232_txd,
  input  logic        rs232_cts_n,
  output logic        busy
);

  // Synchronizer chains and their second-stage taps
  logic [1:0] hasdata_sync_q;
  logic [1:0] arm_ack_sync_q;
  logic [1:0] vr_act_sync_q;
  logic [1:0] cts_n_sync_q;
  logic       vr_act_prev_q;

  logic hasdata_s;
  logic arm_ack_s;
  logic cts_n_s;
  logic vr_rise;

  assign hasdata_s = hasdata_sync_q[1];
  assign arm_ack_s = arm_ack_sync_q[1];
  assign cts_n_s   = cts_n_sync_q[1];
  assign vr_rise   = vr_act_sync_q[1] && !vr_act_prev_q;

  // Two-flop synchronizers for all asynchronous inputs, plus edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hasdata_sync_q <= 2'b00;
      arm_ack_sync_q <= 2'b00;
      vr_act_sync_q  <= 2'b00;
      cts_n_sync_q   <= 2'b11;
      vr_act_prev_q  <= 1'b0;
    end else begin
      hasdata_sync_q <= {hasdata_sync_q[0], buf_out_hasdata};
      arm_ack_sync_q <= {arm_ack_sync_q[0], buf_out_arm_ack};
      vr_act_sync_q  <= {vr_act_sync_q[0], vend_req_act};
      cts_n_sync_q   <= {cts_n_sync_q[0], rs232_cts_n};
      vr_act_prev_q  <= vr_act_sync_q[1];
    end
  end

  logic [15:0] baud_div_q;

  // Vendor request decode: too-small divisors are silently ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_div_q <= BAUD_DIV_DEFAULT;
    end else if (vr_rise && (vend_req_request == VR_SET_BAUD) &&
                 (vend_req_val >= BAUD_DIV_MIN)) begin
      baud_div_q <= vend_req_val;
    end
  end

  out_state_e  state_q;
  logic [9:0]  len_q;
  logic [9:0]  idx_q;
  logic [8:0]  addr_q;
  logic [7:0]  hold_q;
  logic        hold_valid_q;
  logic        arm_q;
  logic        busy_q;

  logic        tx_ready;
  logic        tx_txd;
  logic        tx_start;

  // CTS is only consulted here, so it gates frame starts and nothing else
  assign tx_start = (state_q == ST_SEND) && hold_valid_q && tx_ready && !cts_n_s;

  // Packet FSM; addr_q is kept equal to the byte being fetched so the
  // two-clock buffer latency lines up with the WAIT2 capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= 10'd0;
      idx_q        <= 10'd0;
      addr_q       <= 9'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      arm_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hasdata_s) begin
            len_q        <= clamp_len(buf_out_len);
            idx_q        <= 10'd0;
            addr_q       <= 9'd0;
            hold_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            if (buf_out_len == 10'd0) begin
              arm_q   <= 1'b1;
              state_q <= ST_ARM;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT1;
        ST_WAIT1: state_q <= ST_WAIT2;
        ST_WAIT2: begin
          hold_q       <= buf_out_q;
          hold_valid_q <= 1'b1;
          idx_q        <= idx_q + 10'd1;
          if ((idx_q + 10'd1) < len_q) begin
            addr_q <= idx_q[8:0] + 9'd1;
          end
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (hold_valid_q) begin
            if (tx_start) begin
              hold_valid_q <= 1'b0;
            end
          end else if (idx_q < len_q) begin
            state_q <= ST_FETCH;
          end else if (tx_ready) begin
            arm_q   <= 1'b1;
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (arm_ack_s) begin
            arm_q   <= 1'b0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!hasdata_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_8n1 u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tx_start),
    .data    (hold_q),
    .div     (baud_div_q),
    .txd     (tx_txd),
    .ready   (tx_ready)
  );

  assign buf_out_addr = addr_q;
  assign buf_out_arm  = arm_q;
  assign busy         = busy_q;
  assign rs232_txd    = tx_txd;

endmodule
`default_nettype wire

// File: tb/tb_io_rs232_out.sv
`default_nettype none
// ============================================================================
// tb_io_rs232_out
//   Directed bench for io_rs232_out with a two-clock-latency buffer model
//   and a simple endpoint handshake.
//   Revision: 1.0
// ============================================================================
module tb_io_rs232_out;

  logic        clk;
  logic        reset_n;
  logic [8:0]  addr;
  logic [7:0]  buf_q;
  logic [9:0]  buf_out_len;
  logic        buf_out_hasdata;
  logic        arm;
  logic        arm_ack;
  logic        vend_req_act;
  logic [7:0]  vend_req_request;
  logic [15:0] vend_req_val;
  logic        txd;
  logic        cts_n;
  logic        busy;

  int total;
  int bad;

  logic [7:0] mem [512];
  logic [7:0] q1;

  io_rs232_out dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .buf_out_addr     (addr),
    .buf_out_q        (buf_q),
    .buf_out_len      (buf_out_len),
    .buf_out_hasdata  (buf_out_hasdata),
    .buf_out_arm      (arm),
    .buf_out_arm_ack  (arm_ack),
    .vend_req_act     (vend_req_act),
    .vend_req_request (vend_req_request),
    .vend_req_val     (vend_req_val),
    .rs232_txd        (txd),
    .rs232_cts_n      (cts_n),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Endpoint buffer: data valid two clocks after the address
  always @(posedge clk) begin
    q1    <= mem[addr];
    buf_q <= q1;
  end

  // Waits for a start bit, then checks every clock of the first nbits bits
  task automatic expect_frame(input logic [7:0] exp, input int div, input int max_wait,
                              input int nbits, input string name);
    logic [9:0] want;
    logic [9:0] got;
    logic [9:0] mask;
    int waited;
    int badclk;
    want = {1'b1, exp, 1'b0};
    got = '0;
    mask = 10'((1 << nbits) - 1);
    badclk = 0;
    @(negedge clk);
    waited = 1;
    while (txd !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (txd !== 1'b0) begin
      bad++;
      $display("FAIL %s start: txd=%b after %0d clocks, want start bit within %0d", name, txd, waited, max_wait);
    end else begin
      for (int b = 0; b < nbits; b++) begin
        for (int c = 0; c < div; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (txd !== want[b]) badclk++;
          if (c == div / 2) got[b] = txd;
        end
      end
      total++;
      if (badclk != 0 || (got & mask) !== (want & mask)) begin
        bad++;
        $display("FAIL %s frame: got=%b with %0d wrong clocks, want=%b", name, got & mask, badclk, want & mask);
      end
    end
  endtask

  // Endpoint side of the re-arm handshake
  task automatic ep_complete(input string name);
    int n;
    n = 0;
    while (arm !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (arm !== 1'b1) begin bad++; $display("FAIL %s arm_req: arm=%b want 1", name, arm); end
    buf_out_hasdata = 1'b0;
    arm_ack = 1'b1;
    n = 0;
    while (arm !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (arm !== 1'b0) begin bad++; $display("FAIL %s arm_drop: arm=%b want 0", name, arm); end
    arm_ack = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_clear: busy=%b want 0", name, busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_baud(input logic [15:0] val);
    vend_req_request = 8'h02;
    vend_req_val = val;
    @(negedge clk);
    vend_req_act = 1'b1;
    repeat (4) @(negedge clk);
    vend_req_act = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    buf_out_len = 10'd0;
    buf_out_hasdata = 1'b0;
    arm_ack = 1'b0;
    vend_req_act = 1'b0;
    vend_req_request = 8'h00;
    vend_req_val = 16'd0;
    cts_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    total++; if (arm !== 1'b0) begin bad++; $display("FAIL reset_arm: got %b want 0", arm); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (addr !== 9'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", addr); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_basic();
    mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h00;
    buf_out_len = 10'd3;
    buf_out_hasdata = 1'b1;
    expect_frame(8'h55, 16, 8, 10, "basic_b0");
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    expect_frame(8'hA3, 16, 1, 10, "basic_b1");
    expect_frame(8'h00, 16, 1, 10, "basic_b2");
    total++; if (arm !== 1'b0) begin bad++; $display("FAIL basic_arm_early: got %b want 0", arm); end
    @(negedge clk);
    total++; if (arm !== 1'b1) begin bad++; $display("FAIL basic_arm_rise: got %b want 1", arm); end
    ep_complete("basic");
  endtask

  task automatic test_empty();
    int n;
    int lows;
    n = 0;
    lows = 0;
    buf_out_len = 10'd0;
    buf_out_hasdata = 1'b1;
    while (arm !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
      if (txd !== 1'b1) lows++;
    end
    total++;
    if (arm !== 1'b1 || n > 5) begin bad++; $display("FAIL empty_arm: arm=%b after %0d clocks, want 1 within 5", arm, n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL empty_busy: got %b want 1", busy); end
    ep_complete("empty");
    total++; if (lows != 0) begin bad++; $display("FAIL empty_txd: %0d low clocks, want 0", lows); end
  endtask

  task automatic test_flow_control();
    int lows;
    mem[0] = 8'h3C; mem[1] = 8'hE1;
    buf_out_len = 10'd2;
    buf_out_hasdata = 1'b1;
    fork
      expect_frame(8'h3C, 16, 8, 10, "flow_b0");
      begin : b_cts
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 12) begin @(negedge clk); n++; end
        repeat (66) @(negedge clk);
        cts_n = 1'b1;
      end
    join
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL flow_hold: %0d low clocks while CTS off, want 0", lows); end
    cts_n = 1'b0;
    expect_frame(8'hE1, 16, 3, 10, "flow_b1");
    ep_complete("flow");
  endtask

  task automatic test_baud_change();
    mem[0] = 8'h69; mem[1] = 8'h2D;
    buf_out_len = 10'd2;
    buf_out_hasdata = 1'b1;
    fork
      expect_frame(8'h69, 16, 8, 10, "baud_old_div");
      begin : b_req
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 12) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        set_baud(16'd32);
      end
    join
    expect_frame(8'h2D, 32, 1, 10, "baud_new_div");
    ep_complete("baud");
    set_baud(16'd8);
    mem[0] = 8'hB4;
    buf_out_len = 10'd1;
    buf_out_hasdata = 1'b1;
    expect_frame(8'hB4, 32, 8, 10, "baud_below_min");
    ep_complete("baud_min");
    set_baud(16'd16);
  endtask

  task automatic test_len_clamp();
    logic done;
    int distinct;
    int aerr;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    done = 1'b0;
    distinct = 0;
    aerr = 0;
    buf_out_len = 10'd600;
    buf_out_hasdata = 1'b1;
    fork
      begin : b_frames
        for (int i = 0; i < 512; i++)
          expect_frame(8'(i) ^ 8'hA5, 16, (i == 0) ? 8 : 1, 10, "clamp_frame");
        total++; if (arm !== 1'b0) begin bad++; $display("FAIL clamp_arm_early: got %b want 0", arm); end
        @(negedge clk);
        total++; if (arm !== 1'b1) begin bad++; $display("FAIL clamp_arm_rise: got %b want 1", arm); end
        done = 1'b1;
      end
      begin : b_mon
        logic seen [512];
        int prev;
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        prev = -1;
        while (!done) begin
          @(negedge clk);
          if (busy === 1'b1 && int'(addr) != prev) begin
            if (seen[addr]) aerr++;
            else if (prev >= 0 && int'(addr) != prev + 1) aerr++;
            seen[addr] = 1'b1;
            distinct++;
            prev = int'(addr);
          end
        end
      end
    join
    total++;
    if (distinct != 512 || aerr != 0) begin
      bad++;
      $display("FAIL clamp_addr: %0d addresses with %0d order errors, want 512 with 0", distinct, aerr);
    end
    ep_complete("clamp");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    mem[0] = 8'hC3;
    buf_out_len = 10'd1;
    buf_out_hasdata = 1'b1;
    n = 0;
    while (txd !== 1'b0 && n < 12) begin @(negedge clk); n++; end
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rstmid_start: got %b want 0", txd); end
    repeat (100) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rstmid_bit5: got %b want 0", txd); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    total++; if (arm !== 1'b0) begin bad++; $display("FAIL rstmid_arm: got %b want 0", arm); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    buf_out_hasdata = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    mem[0] = 8'h02;
    buf_out_hasdata = 1'b1;
    expect_frame(8'h02, 1085, 8, 4, "rst_default_div");
    #2 reset_n = 1'b0;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst2_txd: got %b want 1", txd); end
    buf_out_hasdata = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    set_baud(16'd16);
    test_basic();
    test_empty();
    test_flow_control();
    test_baud_change();
    test_len_clamp();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #970000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/io_rs232_out.md
# io_rs232_out

USB-OUT-to-RS-232 transmit path for the Daisho RS-232 target. Reads packets that the host commits to the USB OUT endpoint buffer and serializes each byte onto the DCE-side TXD line as 8N1 UART frames, with CTS flow control. When a packet has been fully sent, it re-arms the endpoint. It is the host-to-line counterpart of the line-to-host capture path, and shares the same vendor-request bus.

## Interface
- `BAUD_DIV_DEFAULT`, 1085: clocks per bit after reset (125 MHz / 115200).
- `BAUD_DIV_MIN`, 16: smallest divisor a vendor request may set.
- `VR_SET_BAUD`, 8'h02: vendor request code that sets the divisor.
- `clk`  in  1  system clock; the block has one clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `buf_out_addr`  out  9  OUT endpoint buffer read address.
- `buf_out_q`  in  8  buffer read data. Valid 2 clocks after the address is presented.
- `buf_out_len`  in  10  committed packet length in bytes. Stable while `buf_out_hasdata` is high.
- `buf_out_hasdata`  in  1  a packet is committed and waiting. Asynchronous to `clk`.
- `buf_out_arm`  out  1  request the endpoint to accept the next packet.
- `buf_out_arm_ack`  in  1  endpoint acknowledgement of arm. Asynchronous to `clk`.
- `vend_req_act`  in  1  vendor request active. Asynchronous to `clk`.
- `vend_req_request`  in  8  vendor request code.
- `vend_req_val`  in  16  vendor request wValue.
- `rs232_txd`  out  1  serial output. Idles high.
- `rs232_cts_n`  in  1  clear-to-send, active low. Asynchronous to `clk`.
- `busy`  out  1  high from packet accept until re-arm is acknowledged.

## Operation
- Synchronizers: `buf_out_hasdata`, `buf_out_arm_ack`, `vend_req_act` and `rs232_cts_n` each pass through a 2-flop synchronizer. All logic uses the second stage.
- Vendor requests:
  - A rising edge of synchronized `vend_req_act` with `vend_req_request == VR_SET_BAUD` loads `vend_req_val` into `baud_div`.
  - If `vend_req_val < BAUD_DIV_MIN`, the request is ignored.
  - A new divisor takes effect at the next start bit and never changes a frame already in progress.
- Frame format: start bit (0), data bits 0 through 7 (LSB first), stop bit (1). Each bit lasts exactly `baud_div` clocks.
- FSM states:
  - IDLE: when `hasdata` is high, latch `len = min(buf_out_len, 512)`, set `idx = 0`, raise `busy`, and go to FETCH. If `len == 0`, go directly to ARM.
  - FETCH: drive `buf_out_addr = idx`, then go to WAIT1.
  - WAIT1: go to WAIT2.
  - WAIT2: capture `buf_out_q` into the hold register, set `hold_valid`, increment `idx`, and go to SEND.
  - SEND:
    - If `hold_valid`, the serializer is ready, and CTS is asserted (`cts_n` low), start the serializer with the hold byte and clear `hold_valid`.
    - Once the hold register is empty and `idx < len`, go to FETCH to prefetch the next byte while the current frame is on the line.
    - When `idx == len`, `hold_valid` is clear and the serializer is ready, go to ARM.
  - ARM: assert `buf_out_arm` and hold it until synchronized `arm_ack` is high, then go to DRAIN.
  - DRAIN: deassert `buf_out_arm`. Wait for `hasdata` low, then clear `busy` and go to IDLE.
- Flow control: CTS is sampled only at frame start. If CTS deasserts mid-frame, the current frame completes and the next one is held until CTS reasserts.
- Widths:
  - `idx`: 10 bits, compared against the clamped `len`. `buf_out_addr = idx[8:0]`.
  - Baud counter: 16 bits, counts down from `baud_div - 1`.
  - Bit counter: 4 bits, counts 0 to 9.

## Timing
- Reset values:
  - `rs232_txd` = 1, `buf_out_arm` = 0, `busy` = 0, `buf_out_addr` = 0.
  - `baud_div` = `BAUD_DIV_DEFAULT`; the FSM is in IDLE.
  - These take effect asynchronously on `reset_n` low.
- Reset mid-frame: `rs232_txd` returns high immediately, and the partial frame is lost.
- Latency:
  - From `buf_out_hasdata` rising to the first start bit is at most 8 clocks: 2 synchronizer clocks, 1 for IDLE, 3 to fetch, 1 to start, plus the output register.
  - The serializer's `txd` changes 1 clock after a start request.
- Back-to-back bytes: with CTS asserted, the next start bit begins on the clock immediately after the previous stop bit ends, so there is no idle gap.
- Re-arm: `buf_out_arm` rises 1 clock after the last stop bit completes.

## Structure
- Shared package `rs232_pkg`:
  - vendor request codes (`VR_READ = 8'h01`, `VR_SET_BAUD = 8'h02`);
  - FSM state encoding;
  - `BAUD_DIV_DEFAULT` and `BAUD_DIV_MIN`.
- Sub-module `uart_tx_8n1`:
  - inputs: `clk`, `reset_n`, `start`, `data[7:0]`, `div[15:0]`;
  - outputs: `txd`, `ready`;
  - latches `div` on `start`;
  - `ready` is high when idle, and also during the stop bit's last clock.
- The top level holds the synchronizers, the vendor-request decode, the FSM and the prefetch register.

## Test plan
- Basic packet: `baud_div = 16`; packet 0x55, 0xA3, 0x00 with `len = 3` -> `txd` shows three 160-clock frames, LSB first, with no gaps, then `buf_out_arm` rises 1 clock after the final stop bit.
- Empty packet: `len = 0` -> `buf_out_arm` is asserted within 5 clocks of `hasdata`, and `txd` stays high throughout.
- Flow control: `rs232_cts_n` goes high during bit 3 of byte 0 of a 2-byte packet -> byte 0 completes, `txd` stays high, and byte 1's start bit begins 3 clocks or fewer after CTS reasserts.
- Baud change: vendor request 0x02 with val = 32 mid-frame -> the current frame keeps 16 clocks/bit and the next frame uses 32. A request with val = 8 leaves the divisor unchanged.
- Length clamp and addressing: `len = 600` -> exactly 512 frames, and `buf_out_addr` covers 0 to 511 once each.
- Reset mid-frame: `reset_n` goes low during data bit 5 -> `txd` = 1 and `arm` = 0 the same clock. After release, the next packet transmits normally at `BAUD_DIV_DEFAULT`.
